instr_queue: RTL and testbench
==============================

# instr_queue

Circular FIFO between the fetch stage and decode/dispatch. Fetch pushes one `{instr, pc, pc_next}` entry per cycle while `enqueue` is high. Decode pops one entry per cycle through a show-ahead head port. A branch/mispredict flush empties the queue in one cycle, and `iq_full` back-pressures fetch.

## Interface
- `DEPTH`, 16: number of entries; power of two, at least 2.
- `PTR_W`, `$clog2(DEPTH)`: read/write pointer width; derived, not overridden.
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst_n`  in  1: synchronous reset, active-low; clears pointers and count.
- `flush`  in  1: fetch `branch` signal; discards all entries.
- `enqueue`  in  1: push request from fetch.
- `instr_in`  in  32: instruction word from the icache.
- `pc_in`  in  32: PC of `instr_in`.
- `pc_next_in`  in  32: predicted next PC of `instr_in`.
- `iq_full`  out  1: count == `DEPTH`; goes to fetch.
- `iq_empty`  out  1: count == 0.
- `dequeue`  in  1: pop request from decode.
- `iq_valid`  out  1: `!iq_empty`; the head entry is valid.
- `instr_out`  out  32: head instruction, or 0 when empty.
- `pc_out`  out  32: head PC, or 0 when empty.
- `pc_next_out`  out  32: head predicted next PC, or 0 when empty.
- `count`  out  PTR_W+1: current occupancy, 0..`DEPTH`.

## Operation
- State:
  - `wr_ptr`, `rd_ptr`: `PTR_W`-bit pointers.
  - `count`: `PTR_W+1` bits.
  - Entry array of `DEPTH` × 96 bits; the array is not reset.
- Full/empty come from `count` only. Pointer equality alone is ambiguous.
- Effective push: `push = enqueue && !iq_full && !flush`.
- Effective pop: `pop = dequeue && iq_valid && !flush`.
- On push:
  - write the entry at `wr_ptr`;
  - `wr_ptr` increments modulo `DEPTH`, wrapping naturally from `DEPTH-1` to 0.
- On pop: `rd_ptr` increments modulo `DEPTH`.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle:
  - allowed whenever both are qualified;
  - when full, push is rejected because `iq_full` is state-based, not bypassed by the same-cycle pop;
  - when empty, pop is rejected and no write-to-read bypass is performed.
- Flush:
  - next state is `wr_ptr = rd_ptr = count = 0`;
  - a same-cycle `enqueue` or `dequeue` is ignored.
- Priority order: reset > flush > push/pop.
- Enqueue while full, or dequeue while empty: ignored, with no state change. Not an error.
- Head outputs are a combinational read of `entry[rd_ptr]`, gated to 0 when `iq_empty`.

## Timing
- Reset (`rst_n` = 0 at a clock edge), outputs the next cycle:
  - `count` = 0, `iq_empty` = 1, `iq_full` = 0, `iq_valid` = 0;
  - data outputs = 0.
- Reset asserted mid-operation discards all contents. There is no partial drain.
- Push-to-visible latency is 1 cycle: an entry pushed at edge N is on the head outputs after edge N, i.e. during cycle N+1.
- Pop: the new head appears in the cycle after the dequeue edge.
- `iq_full` and `iq_empty` change only on clock edges and are functions of `count`.
- Flush latency: queue is empty one cycle after `flush` is sampled.

## Structure
- Put `iq_entry_t` (packed struct: `instr`, `pc`, `pc_next`; 32 bits each) in the shared `fetch_pkg`.
- Also put in `fetch_pkg`: `IQ_DEPTH_DEFAULT` = 16 and `RESET_PC` = 32'h1eceb000.
- No sub-module. The entry array is a flop array inside `instr_queue`.

## Test plan
- **Reset then single entry.** Reset, then push `instr` = 32'h00000013, `pc` = 32'h1eceb000, `pc_next` = 32'h1eceb004.
  - Next cycle: `iq_valid` = 1, `count` = 1, head fields match.
  - Pop; the cycle after: `iq_empty` = 1, data outputs = 0.
- **Fill and overflow.** Push 16 entries with `pc` = 32'h1eceb000 + 4·i.
  - `iq_full` = 1 after the 16th push.
  - A 17th `enqueue` leaves `count` = 16.
  - Draining returns PCs in order i = 0..15.
- **Wrap-around.** Push 12, pop 10, push 12 more.
  - `count` = 14, no full flag.
  - Pop order is continuous across the `wr_ptr` wrap.
- **Simultaneous push/pop.**
  - `count` = 5 with both asserted: `count` stays 5 and the head advances.
  - `count` = 16 with both asserted: `count` becomes 15 and the new data is dropped.
  - `count` = 0 with both asserted: `count` becomes 1.
- **Flush.** With `count` = 9, assert `flush`, `enqueue` and `dequeue` together.
  - Next cycle: `count` = 0, `iq_empty` = 1.
  - A following push of `pc` = 32'h1eceb100 is the head.
- **Mid-operation reset.** With `count` = 7, drive `rst_n` = 0 for one edge.
  - All outputs show reset values; `dequeue` afterwards is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the fetch stage and its instruction queue.
//   iq_entry_t       : one queued fetch result {instr, pc, pc_next}, 96 bits
//   IQ_DEPTH_DEFAULT : default instruction queue depth
//   RESET_PC         : address fetch starts from after reset
package fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } iq_entry_t;

  localparam int          IQ_DEPTH_DEFAULT = 16;
  localparam logic [31:0] RESET_PC         = 32'h1eceb000;

endpackage

// File: rtl/instr_queue.sv
// instr_queue
// Circular FIFO between fetch and decode/dispatch. Fetch pushes one
// {instr, pc, pc_next} entry per cycle; decode pops through a show-ahead
// head port. A flush (branch/mispredict) empties the queue in one cycle.
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst_n        : synchronous active-low reset, clears pointers and count
//   flush        : discard every entry; same-cycle enqueue/dequeue ignored
//   enqueue      : push request from fetch
//   instr_in     : instruction word to push
//   pc_in        : PC of instr_in
//   pc_next_in   : predicted next PC of instr_in
//   iq_full      : occupancy == DEPTH, back-pressures fetch
//   iq_empty     : occupancy == 0
//   dequeue      : pop request from decode
//   iq_valid     : head entry is valid
//   instr_out    : head instruction, 0 when empty
//   pc_out       : head PC, 0 when empty
//   pc_next_out  : head predicted next PC, 0 when empty
//   count        : current occupancy, 0..DEPTH
module instr_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = IQ_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enqueue,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      pc_next_in,
  output logic             iq_full,
  output logic             iq_empty,
  input  logic             dequeue,
  output logic             iq_valid,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_next_out,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  iq_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  iq_entry_t        head;

  // Full/empty are derived from count alone, since wr_ptr == rd_ptr is
  // ambiguous between the two. Being state-based, a same-cycle pop never
  // frees a slot for a push while full, and an empty queue never bypasses
  // the incoming entry to the head.
  assign iq_full  = (count == FULL_COUNT);
  assign iq_empty = (count == '0);
  assign iq_valid = !iq_empty;

  assign push = enqueue && !iq_full && !flush;
  assign pop  = dequeue && iq_valid && !flush;

  // The entry array carries no reset: an entry is only observable after
  // being written, and the head outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= '{instr: instr_in, pc: pc_in, pc_next: pc_next_in};
    end
  end

  // Pointers and occupancy. Reset beats flush, flush beats push/pop.
  // Pointers are DEPTH-sized (power of two) so they wrap by overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Show-ahead head read, forced to zero while the queue is empty so
  // decode never sees stale or uninitialised array contents.
  always_comb begin
    head        = entries[rd_ptr];
    instr_out   = '0;
    pc_out      = '0;
    pc_next_out = '0;
    if (!iq_empty) begin
      instr_out   = head.instr;
      pc_out      = head.pc;
      pc_next_out = head.pc_next;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue
// Directed self-checking bench for instr_queue (DEPTH = 16).
module tb_instr_queue;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        enqueue;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [31:0] pc_next_in;
  logic        iq_full;
  logic        iq_empty;
  logic        dequeue;
  logic        iq_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_next_out;
  logic [4:0]  iq_count;

  int errors = 0;
  int checks = 0;

  instr_queue #(.DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .enqueue     (enqueue),
    .instr_in    (instr_in),
    .pc_in       (pc_in),
    .pc_next_in  (pc_next_in),
    .iq_full     (iq_full),
    .iq_empty    (iq_empty),
    .dequeue     (dequeue),
    .iq_valid    (iq_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .pc_next_out (pc_next_out),
    .count       (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then release the
  // controls; outputs are sampled 1 time unit after the edge.
  task automatic do_cycle(input logic en, input logic deq, input logic fl,
                          input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] pcn);
    enqueue    = en;
    dequeue    = deq;
    flush      = fl;
    instr_in   = ins;
    pc_in      = pc;
    pc_next_in = pcn;
    @(posedge clk);
    #1;
    enqueue = 1'b0;
    dequeue = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc);
    do_cycle(1'b1, 1'b0, 1'b0, ~pc, pc, pc + 32'd4);
  endtask

  task automatic pop();
    do_cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    do_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    checks++; if (iq_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", iq_count); end
    checks++; if ({iq_empty, iq_full, iq_valid} !== 3'b100) begin errors++; $display("FAIL reset_flags: got empty/full/valid %b expected 100", {iq_empty, iq_full, iq_valid}); end
    checks++; if ({instr_out, pc_out, pc_next_out} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {instr_out, pc_out, pc_next_out}); end
  endtask

  task automatic test_single();
    do_cycle(1'b1, 1'b0, 1'b0, 32'h00000013, 32'h1eceb000, 32'h1eceb004);
    checks++; if (iq_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", iq_valid); end
    checks++; if (iq_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", iq_count); end
    checks++; if (instr_out !== 32'h00000013) begin errors++; $display("FAIL single_instr: got %h expected 00000013", instr_out); end
    checks++; if (pc_out !== 32'h1eceb000) begin errors++; $display("FAIL single_pc: got %h expected 1eceb000", pc_out); end
    checks++; if (pc_next_out !== 32'h1eceb004) begin errors++; $display("FAIL single_pc_next: got %h expected 1eceb004", pc_next_out); end
    pop();
    checks++; if (iq_empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b expected 1", iq_empty); end
    checks++; if ({instr_out, pc_out, pc_next_out} !== 96'd0) begin errors++; $display("FAIL single_pop_data: got %h expected 0", {instr_out, pc_out, pc_next_out}); end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] exp_pc;
    for (int i = 0; i < 16; i++) begin
      push(RESET_PC + 32'(4 * i));
      checks++; if (iq_full !== (i == 15)) begin errors++; $display("FAIL fill_full_%0d: got %b expected %b", i, iq_full, (i == 15)); end
    end
    checks++; if (iq_count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d expected 16", iq_count); end
    push(32'hdeadbeef);
    checks++; if (iq_count !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d expected 16", iq_count); end
    for (int i = 0; i < 16; i++) begin
      exp_pc = RESET_PC + 32'(4 * i);
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL drain_pc_%0d: got %h expected %h", i, pc_out, exp_pc); end
      checks++; if (instr_out !== ~exp_pc || pc_next_out !== exp_pc + 32'd4) begin errors++; $display("FAIL drain_fields_%0d: got %h/%h expected %h/%h", i, instr_out, pc_next_out, ~exp_pc, exp_pc + 32'd4); end
      pop();
    end
    checks++; if (iq_empty !== 1'b1 || iq_count !== 5'd0) begin errors++; $display("FAIL drain_empty: got empty=%b count=%0d expected 1/0", iq_empty, iq_count); end
  endtask

  task automatic test_wrap();
    logic [31:0] base;
    logic [31:0] exp_pc;
    base = 32'h20000000;
    for (int i = 0; i < 12; i++) push(base + 32'(4 * i));
    for (int i = 0; i < 10; i++) begin
      exp_pc = base + 32'(4 * i);
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL wrap_first_pc_%0d: got %h expected %h", i, pc_out, exp_pc); end
      pop();
    end
    for (int i = 12; i < 24; i++) push(base + 32'(4 * i));
    checks++; if (iq_count !== 5'd14) begin errors++; $display("FAIL wrap_count: got %0d expected 14", iq_count); end
    checks++; if (iq_full !== 1'b0) begin errors++; $display("FAIL wrap_full: got %b expected 0", iq_full); end
    for (int i = 10; i < 24; i++) begin
      exp_pc = base + 32'(4 * i);
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL wrap_pc_%0d: got %h expected %h", i, pc_out, exp_pc); end
      pop();
    end
    checks++; if (iq_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", iq_empty); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_q[$];
    logic [31:0] base;
    logic [31:0] exp_pc;
    base = 32'h30000000;
    for (int i = 0; i < 5; i++) begin
      push(base + 32'(4 * i));
      exp_q.push_back(base + 32'(4 * i));
    end
    // count = 5: both accepted, count unchanged, head advances
    do_cycle(1'b1, 1'b1, 1'b0, 32'h11111111, 32'h30000100, 32'h30000104);
    void'(exp_q.pop_front());
    exp_q.push_back(32'h30000100);
    checks++; if (iq_count !== 5'd5) begin errors++; $display("FAIL simul5_count: got %0d expected 5", iq_count); end
    checks++; if (pc_out !== base + 32'd4) begin errors++; $display("FAIL simul5_head: got %h expected %h", pc_out, base + 32'd4); end
    for (int i = 0; i < 11; i++) begin
      push(32'h30000200 + 32'(4 * i));
      exp_q.push_back(32'h30000200 + 32'(4 * i));
    end
    checks++; if (iq_full !== 1'b1) begin errors++; $display("FAIL simul16_full: got %b expected 1", iq_full); end
    // count = 16: pop accepted, push rejected
    do_cycle(1'b1, 1'b1, 1'b0, 32'h22222222, 32'h30000ddd, 32'h30000de1);
    void'(exp_q.pop_front());
    checks++; if (iq_count !== 5'd15) begin errors++; $display("FAIL simul16_count: got %0d expected 15", iq_count); end
    for (int i = 0; i < 15; i++) begin
      exp_pc = exp_q.pop_front();
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL simul_drain_pc_%0d: got %h expected %h", i, pc_out, exp_pc); end
      pop();
    end
    checks++; if (iq_empty !== 1'b1) begin errors++; $display("FAIL simul_drain_empty: got %b expected 1 (dropped entry kept?)", iq_empty); end
    // count = 0: pop rejected, push accepted, no bypass
    do_cycle(1'b1, 1'b1, 1'b0, 32'h33333333, 32'h30000aaa, 32'h30000aae);
    checks++; if (iq_count !== 5'd1) begin errors++; $display("FAIL simul0_count: got %0d expected 1", iq_count); end
    checks++; if (pc_out !== 32'h30000aaa) begin errors++; $display("FAIL simul0_head: got %h expected 30000aaa", pc_out); end
    pop();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) push(32'h40000000 + 32'(4 * i));
    checks++; if (iq_count !== 5'd9) begin errors++; $display("FAIL flush_pre_count: got %0d expected 9", iq_count); end
    do_cycle(1'b1, 1'b1, 1'b1, 32'h44444444, 32'h40000fff, 32'h40001003);
    checks++; if (iq_count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", iq_count); end
    checks++; if (iq_empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", iq_empty); end
    push(32'h1eceb100);
    checks++; if (pc_out !== 32'h1eceb100 || iq_count !== 5'd1) begin errors++; $display("FAIL flush_head: got pc=%h count=%0d expected 1eceb100/1", pc_out, iq_count); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) push(32'h50000000 + 32'(4 * i));
    checks++; if (iq_count !== 5'd7) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 7", iq_count); end
    rst_n = 1'b0;
    do_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    checks++; if (iq_count !== 5'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", iq_count); end
    checks++; if ({iq_empty, iq_full, iq_valid} !== 3'b100) begin errors++; $display("FAIL midrst_flags: got empty/full/valid %b expected 100", {iq_empty, iq_full, iq_valid}); end
    checks++; if ({instr_out, pc_out, pc_next_out} !== 96'd0) begin errors++; $display("FAIL midrst_data: got %h expected 0", {instr_out, pc_out, pc_next_out}); end
    pop();
    checks++; if (iq_count !== 5'd0 || iq_empty !== 1'b1) begin errors++; $display("FAIL midrst_deq_ignored: got count=%0d empty=%b expected 0/1", iq_count, iq_empty); end
  endtask

  initial begin
    rst_n      = 1'b1;
    flush      = 1'b0;
    enqueue    = 1'b0;
    dequeue    = 1'b0;
    instr_in   = '0;
    pc_in      = '0;
    pc_next_in = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill_overflow();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
